// File: rtl/sum_of_squares_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sum_of_squares_seq
//  Description : Sequential x*x + y*y using one shared shift-and-add datapath.
//                One operand pair in flight; valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_of_squares_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH:0]   sum_sq,
    output logic               busy
);

    localparam int ACC_W = 2 * WIDTH + 1;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = IDX_W + 1;

    // Last bit index of an operand; SQ_Y runs one extra step to publish acc.
    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_FINAL = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_X = 2'd1,
        SQ_Y = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_sum_sq;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_operand;
    logic [IDX_W-1:0]   w_idx;
    logic               w_bit;
    logic [ACC_W-1:0]   w_addend;
    logic [ACC_W-1:0]   w_sum;

    // Shared shift-and-add: the operand being squared is selected by state.
    assign w_operand = (r_state == SQ_X) ? r_x : r_y;
    assign w_idx     = r_cnt[IDX_W-1:0];
    assign w_bit     = w_operand[w_idx];
    assign w_addend  = ACC_W'(w_operand) << w_idx;
    assign w_sum     = r_acc + w_addend;

    assign in_ready  = (r_state == IDLE) && ena;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign sum_sq    = r_sum_sq;

    // State register; ena low freezes the machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (ena) begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (in_valid)               w_next_state = SQ_X;
            SQ_X: if (r_cnt == C_CNT_LAST)    w_next_state = SQ_Y;
            SQ_Y: if (r_cnt == C_CNT_FINAL)   w_next_state = DONE;
            DONE: if (out_ready)              w_next_state = IDLE;
            default:                          w_next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, accumulation, result publish and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum_sq    <= '0;
            r_out_valid <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x   <= x;
                        r_y   <= y;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                SQ_X: begin
                    if (w_bit) r_acc <= w_sum;
                    if (r_cnt == C_CNT_LAST) r_cnt <= '0;
                    else                     r_cnt <= r_cnt + 1'b1;
                end
                SQ_Y: begin
                    if (r_cnt == C_CNT_FINAL) begin
                        r_sum_sq    <= r_acc;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        if (w_bit) r_acc <= w_sum;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (r_out_valid && out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_of_squares_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_of_squares_seq
//  Description : Directed scoreboard bench for sum_of_squares_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_of_squares_seq;

    localparam int WIDTH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic              out_valid;
    logic              out_ready;
    logic [2*WIDTH:0]  sum_sq;
    logic              busy;

    int vectors    = 0;
    int miscompares = 0;
    int sb[$];

    sum_of_squares_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_sq    (sum_sq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [WIDTH-1:0] ax, input logic [WIDTH-1:0] ay,
                          input bit push);
        int n;
        n = 0;
        x = ax;
        y = ay;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", int'(in_ready), 1);
        end else if (push) begin
            sb.push_back(int'(ax) * int'(ax) + int'(ay) * int'(ay));
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!out_valid && c < 100) begin
            step();
            c++;
        end
    endtask

    // Scoreboard: compare every transfer that the next rising edge completes.
    always @(negedge clk) begin
        if (rst_n && ena && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", int'(out_valid), 0);
            end else begin
                chk("sum_sq", int'(sum_sq), sb.pop_front());
            end
        end
    end

    initial begin
        int c;
        int c2;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0;
        repeat (2) step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sum_sq", int'(sum_sq), 0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", int'(in_ready), 1);

        // 3*3 + 4*4 with latency and single-cycle pulse.
        accept(8'd3, 8'd4, 1'b1);
        chk("busy_after_accept", int'(busy), 1);
        wait_valid(c);
        chk("latency_3_4", c, 17);
        chk("in_ready_in_done", int'(in_ready), 0);
        step();
        chk("pulse_3_4", int'(out_valid), 0);

        // Extremes.
        accept(8'd255, 8'd255, 1'b1);
        wait_valid(c);
        chk("sum_max_direct", int'(sum_sq), 130050);
        step();
        accept(8'd0, 8'd0, 1'b1);
        wait_valid(c);
        chk("latency_0_0", c, 17);
        step();

        // Backpressure: result held, no accept while waiting.
        out_ready = 1'b0;
        accept(8'd12, 8'd5, 1'b1);
        wait_valid(c);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_sum_sq", int'(sum_sq), 169);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_popped", int'(out_valid), 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Input changes and in_valid pulses mid-operation are ignored.
        accept(8'd7, 8'd9, 1'b1);
        x = 8'd200; y = 8'd200; in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        wait_valid(c);
        chk("latency_7_9", c + 3, 17);
        step();
        for (int i = 0; i < 20; i++) step();
        chk("no_second_result", int'(out_valid), 0);
        chk("idle_after_7_9", int'(busy), 0);

        // Enable stall during SQ_X.
        accept(8'd100, 8'd1, 1'b1);
        repeat (2) step();
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_busy", int'(busy), 1);
            chk("stall_out_valid", int'(out_valid), 0);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        ena = 1'b1;
        wait_valid(c2);
        chk("latency_stall", 6 + c2, 21);
        chk("sum_stall_direct", int'(sum_sq), 10001);
        step();

        // Asynchronous reset during SQ_Y discards the operation.
        accept(8'd11, 8'd13, 1'b0);
        repeat (12) step();
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_sum_sq", int'(sum_sq), 0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) chk("stale_valid", int'(out_valid), 0);
        end
        chk("post_rst_idle", int'(busy), 0);
        accept(8'd6, 8'd8, 1'b1);
        wait_valid(c);
        chk("latency_6_8", c, 17);
        step();

        repeat (3) step();
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
